// File: rtl/puf_pkg.sv
// Shared constants for the RO-PUF response controller.
// State codes, default widths and the clear-phase length.
package puf_pkg;

  localparam int unsigned PUF_CHAL_W = 5;
  localparam int unsigned PUF_CNT_W  = 8;
  localparam int unsigned CLR_CYC    = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CLEAR  = 3'd1;
  localparam state_t S_RUN    = 3'd2;
  localparam state_t S_SETTLE = 3'd3;
  localparam state_t S_SAMPLE = 3'd4;
  localparam state_t S_DONE   = 3'd5;

endpackage

// File: rtl/puf_phase_timer.sv
// Phase down-counter shared by CLEAR, RUN and SETTLE.
// Load len-1 on phase entry; done is high in the last phase cycle.
module puf_phase_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: reload on entry, else count down to zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val - W'(1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/puf_resp_ctrl.sv
// RO-PUF measurement controller: walks NUM_BITS challenges,
// times clear/window/settle phases and builds the response word.
module puf_resp_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W   = PUF_CHAL_W,
  parameter int unsigned CNT_W    = PUF_CNT_W,
  parameter int unsigned WINDOW   = 64,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CHAL_W-1:0]   chal_base,
  input  logic [CNT_W-1:0]    count_a,
  input  logic [CNT_W-1:0]    count_b,
  output logic                osc_en,
  output logic                cnt_clr,
  output logic [CHAL_W-1:0]   chal_sel,
  output logic                busy,
  output logic [NUM_BITS-1:0] resp,
  output logic                resp_valid,
  output logic                tie,
  output logic                ovf
);

  localparam int unsigned MAXL0 = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned MAXL  = (MAXL0 > CLR_CYC) ? MAXL0 : CLR_CYC;
  localparam int unsigned TW    = $clog2(MAXL + 1);
  localparam int unsigned IDX_W =
    (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic [NUM_BITS-1:0] resp_q, resp_d;
  logic                vld_q, vld_d;
  logic                tie_q, tie_d;
  logic                ovf_q, ovf_d;
  logic                osc_q, osc_d;
  logic                clr_q, clr_d;
  logic                busy_q, busy_d;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_done;

  puf_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // FSM next state, sampling and accumulation
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    chal_d   = chal_q;
    resp_d   = resp_q;
    vld_d    = vld_q;
    tie_d    = tie_q;
    ovf_d    = ovf_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          chal_d   = chal_base;
          idx_d    = '0;
          resp_d   = '0;
          tie_d    = 1'b0;
          ovf_d    = 1'b0;
          vld_d    = 1'b0;
          state_d  = S_CLEAR;
          tmr_load = 1'b1;
          tmr_val  = TW'(CLR_CYC);
        end
      end
      S_CLEAR: begin
        if (tmr_done) begin
          state_d  = S_RUN;
          tmr_load = 1'b1;
          tmr_val  = TW'(WINDOW);
        end
      end
      S_RUN: begin
        if (tmr_done) begin
          state_d  = S_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = TW'(SETTLE);
        end
      end
      S_SETTLE: begin
        if (tmr_done)
          state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        resp_d[idx_q] = (count_a > count_b);
        if (count_a == count_b)
          tie_d = 1'b1;
        if ((count_a == CNT_MAX) || (count_b == CNT_MAX))
          ovf_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          chal_d   = chal_q + CHAL_W'(1);
          state_d  = S_CLEAR;
          tmr_load = 1'b1;
          tmr_val  = TW'(CLR_CYC);
        end
      end
      S_DONE: begin
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    osc_d  = (state_d == S_RUN);
    clr_d  = (state_d == S_CLEAR);
    busy_d = (state_d != S_IDLE);
  end

  // state and registered outputs; reset aborts any run at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      vld_q   <= 1'b0;
      tie_q   <= 1'b0;
      ovf_q   <= 1'b0;
      osc_q   <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      vld_q   <= vld_d;
      tie_q   <= tie_d;
      ovf_q   <= ovf_d;
      osc_q   <= osc_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
    end
  end

  assign osc_en     = osc_q;
  assign cnt_clr    = clr_q;
  assign chal_sel   = chal_q;
  assign busy       = busy_q;
  assign resp       = resp_q;
  assign resp_valid = vld_q;
  assign tie        = tie_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_puf_resp_ctrl.sv
// Directed bench for puf_resp_ctrl with a result scoreboard
// and per-cycle waveform checks of osc_en/cnt_clr/chal_sel.
module tb_puf_resp_ctrl;

  localparam int RUN_LAT = 569;
  localparam int BIT_LAT = 71;

  typedef struct packed {
    logic [7:0] resp;
    logic       tie;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] chal_base;
  logic [7:0] count_a;
  logic [7:0] count_b;
  logic       osc_en;
  logic       cnt_clr;
  logic [4:0] chal_sel;
  logic       busy;
  logic [7:0] resp;
  logic       resp_valid;
  logic       tie;
  logic       ovf;

  int   mode;
  int   checks;
  int   errors;
  exp_t sb[$];

  puf_resp_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .chal_base  (chal_base),
    .count_a    (count_a),
    .count_b    (count_b),
    .osc_en     (osc_en),
    .cnt_clr    (cnt_clr),
    .chal_sel   (chal_sel),
    .busy       (busy),
    .resp       (resp),
    .resp_valid (resp_valid),
    .tie        (tie),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // oscillator bank stand-in
  always_comb begin
    count_a = 8'd200;
    count_b = 8'd100;
    if (mode == 1) begin
      count_a = {3'b000, chal_sel};
      count_b = 8'd3;
    end else if (mode == 2 && chal_sel == chal_base) begin
      count_b = 8'hFF;
    end
  end

  function automatic exp_t model(input logic [4:0] base, input int md);
    exp_t e;
    logic [4:0] sel;
    logic [7:0] a, b;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      sel = base + 5'(i);
      a = 8'd200;
      b = 8'd100;
      if (md == 1) begin
        a = {3'b000, sel};
        b = 8'd3;
      end else if (md == 2 && i == 0) begin
        b = 8'hFF;
      end
      e.resp[i] = (a > b);
      if (a == b) e.tie = 1'b1;
      if (a == 8'hFF || b == 8'hFF) e.ovf = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input logic [4:0] base, input bit extra);
    exp_t       g;
    int         cyc, osc_len, clr_len, last_clr;
    int         pulses, bad_pulse, overlap, hold, bad_hold, bad_seq;
    logic       po, pc;
    logic [4:0] ps;
    logic [4:0] seq[$];
    sb.push_back(model(base, mode));
    @(negedge clk);
    chal_base = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; osc_len = 0; clr_len = 0; last_clr = 0;
    pulses = 0; bad_pulse = 0; overlap = 0;
    hold = 0; bad_hold = 0; bad_seq = 0;
    po = 1'b0; pc = 1'b0; ps = chal_sel;
    while (!resp_valid && cyc < 2000) begin
      if (osc_en && cnt_clr) overlap++;
      if (cnt_clr) begin
        if (!pc) seq.push_back(chal_sel);
        clr_len++;
      end else if (pc) begin
        last_clr = clr_len;
        clr_len = 0;
      end
      if (osc_en) begin
        if (!po) begin
          pulses++;
          if (last_clr != 2 || !pc) bad_pulse++;
        end
        osc_len++;
      end else if (po) begin
        if (osc_len != 64) bad_pulse++;
        osc_len = 0;
      end
      if (chal_sel != ps) begin
        if (hold != BIT_LAT) bad_hold++;
        hold = 0;
      end
      hold++;
      ps = chal_sel;
      po = osc_en;
      pc = cnt_clr;
      start = extra && (cyc == 100);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, RUN_LAT);
    chk("busy_at_valid", busy, 0);
    chk("osc_pulses", pulses, 8);
    chk("pulse_shape", bad_pulse, 0);
    chk("osc_clr_overlap", overlap, 0);
    chk("chal_hold", bad_hold, 0);
    chk("seq_len", seq.size(), 8);
    for (int i = 0; i < seq.size(); i++)
      if (seq[i] !== base + 5'(i)) bad_seq++;
    chk("chal_seq", bad_seq, 0);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      g = sb.pop_front();
      chk("resp", resp, g.resp);
      chk("tie", tie, g.tie);
      chk("ovf", ovf, g.ovf);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mode = 0;
    rst_n = 1'b0;
    start = 1'b0;
    chal_base = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {osc_en, cnt_clr, chal_sel, busy, resp, resp_valid, tie, ovf}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mode = 0;
    do_run(5'd0, 1'b0);

    mode = 1;
    do_run(5'd0, 1'b0);

    mode = 0;
    do_run(5'd30, 1'b0);

    mode = 0;
    @(negedge clk);
    chal_base = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * BIT_LAT + 2 + 10 - 1) @(negedge clk);
    chk("pre_rst_osc", osc_en, 1);
    chk("pre_rst_chal", chal_sel, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs",
        {osc_en, cnt_clr, chal_sel, busy, resp, resp_valid, tie, ovf}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mode = 1;
    do_run(5'd0, 1'b0);

    mode = 2;
    do_run(5'd0, 1'b1);
    repeat (5) @(negedge clk);
    chk("idle_after_extra", {busy, resp_valid}, 2'b01);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
